// File: rtl/core_packet_rx_fifo_pkg.sv
// Shared definitions for the core packet receive path: default packet width,
// packet field layout, and the per-cycle FIFO operation decode.
package core_packet_rx_fifo_pkg;

    localparam int PKT_W_DEFAULT = 32;

    // Field layout of one core output packet (MSB first).
    typedef struct packed {
        logic [3:0]  tick;
        logic [11:0] axon;
        logic [7:0]  dy;
        logic [7:0]  dx;
    } core_pkt_t;

    // What the FIFO does on the current edge.
    typedef struct packed {
        logic push;   // packet written into the RAM
        logic pop;    // entry read out to packet_in
        logic drop;   // packet discarded because the buffer is full
        logic under;  // read_req seen while empty
    } fifo_op_t;

endpackage

// File: rtl/core_packet_rx_fifo_ram.sv
// Simple dual-port RAM, DEPTH x W: synchronous write, registered read, no reset.
// A read and write to the same address on one edge returns the old contents.
module core_packet_rx_fifo_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/core_packet_rx_fifo.sv
// Receive buffer between the core output packet port and the SoC read side.
// Level register is the authoritative occupancy; flags are derived from it.
module core_packet_rx_fifo
    import core_packet_rx_fifo_pkg::*;
#(
    parameter int PACKET_WIDTH = PKT_W_DEFAULT,
    parameter int DEPTH        = 16,
    parameter int CNT_WIDTH    = 16,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PACKET_WIDTH-1:0]  packet_out,
    input  logic                     packet_out_valid,
    output logic                     packet_out_ready,
    input  logic                     read_req,
    output logic [PACKET_WIDTH-1:0]  packet_in,
    output logic                     packet_in_valid,
    output logic                     input_buffer_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]     drop_count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    pin_vld_q, pin_vld_d;
    logic [PACKET_WIDTH-1:0] pin_hold_q, pin_hold_d;
    logic [PACKET_WIDTH-1:0] ram_rdata;
    logic                    is_empty, is_full;
    fifo_op_t                op;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LW'(DEPTH));

    // Push/pop arbitration: a pop frees a slot for a same-cycle push even when
    // full; an empty FIFO never pops, so there is no fall-through.
    always_comb begin
        op       = '0;
        op.pop   = read_req & ~is_empty;
        op.push  = packet_out_valid & (~is_full | op.pop);
        op.drop  = DROP_ON_FULL & packet_out_valid & is_full & ~op.pop;
        op.under = read_req & is_empty;
    end

    assign packet_out_ready = DROP_ON_FULL ? 1'b1 : (~is_full | read_req);

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (op.push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (op.pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({op.push, op.pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Read side: the RAM read register carries the fresh packet on the strobe
    // cycle; afterwards it is captured so packet_in holds even if the RAM
    // output register is later disturbed.
    always_comb begin
        pin_vld_d  = op.pop;
        pin_hold_d = pin_vld_q ? ram_rdata : pin_hold_q;
    end

    // Read strobe and held packet registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_vld_q  <= 1'b0;
            pin_hold_q <= '0;
        end else begin
            pin_vld_q  <= pin_vld_d;
            pin_hold_q <= pin_hold_d;
        end
    end

    assign packet_in       = pin_vld_q ? ram_rdata : pin_hold_q;
    assign packet_in_valid = pin_vld_q;

    // Sticky status; clear wins over a same-cycle increment or set.
    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_status) begin
            drop_cnt_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (op.drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end
            if (op.under) underflow_d = 1'b1;
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign input_buffer_empty = is_empty;
    assign full               = is_full;
    assign level              = level_q;
    assign drop_count         = drop_cnt_q;
    assign overflow           = overflow_q;
    assign underflow          = underflow_q;

    core_packet_rx_fifo_ram #(
        .W     (PACKET_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (op.push),
        .waddr (wr_ptr_q),
        .wdata (packet_out),
        .re    (op.pop),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

endmodule
